// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared memory access state encoding and bus size defaults
package mem_if_pkg;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MEM_LAST = 600;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;
endpackage

// File: rtl/mem_initiator_if.sv
// mem_initiator_if: CPU request/response and memory strobe bundle
interface mem_initiator_if import mem_if_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic rsp_err;
  logic mem_read;
  logic mem_write;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic mem_rd_done;
  logic mem_wr_done;
  modport master (
    input req_valid, req_we, req_addr, req_wdata, mem_rd_data, mem_rd_done, mem_wr_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_read_addr,
      mem_write_addr, mem_wr_data
  );
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_rd_data, mem_rd_done, mem_wr_done,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_read_addr,
      mem_write_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts wait cycles and flags the last allowed one
module mem_timeout_ctr import mem_if_pkg::*; #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  // expired marks the TIMEOUT-th wait cycle, so the strobe lasts exactly TIMEOUT cycles
  assign expired = cnt == 8'(TIMEOUT - 1);
  // cleared while idle so every wait starts from zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: single-outstanding memory access engine with range check and timeout
module mem_initiator import mem_if_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_LAST = DEF_MEM_LAST,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  mem_initiator_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_LAST);
  state_t state, state_n;
  logic err_n, expired, accept, oor, waiting;
  assign accept = bus.req_ready && bus.req_valid;
  assign oor = bus.req_addr > LAST;
  assign waiting = state == RD_WAIT || state == WR_WAIT;
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en(waiting),
    .expired(expired)
  );
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next state; done wins over a timeout landing in the same cycle
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_n = oor ? RESP : bus.req_we ? WR_WAIT : RD_WAIT;
        err_n = oor;
      end
      RD_WAIT: if (bus.mem_rd_done || expired) begin
        state_n = RESP;
        err_n = !bus.mem_rd_done;
      end
      WR_WAIT: if (bus.mem_wr_done || expired) begin
        state_n = RESP;
        err_n = !bus.mem_wr_done;
      end
      default: state_n = IDLE;
    endcase
  end
  // all outputs are flops decoded from the next state so strobes never glitch
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_read_addr <= '0;
      bus.mem_write_addr <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      bus.req_ready <= state_n == IDLE;
      bus.rsp_valid <= state_n == RESP;
      bus.rsp_err <= err_n;
      bus.rsp_rdata <= (state == RD_WAIT && bus.mem_rd_done) ? bus.mem_rd_data : '0;
      bus.mem_read <= state_n == RD_WAIT;
      bus.mem_write <= state_n == WR_WAIT;
      if (accept && !oor && !bus.req_we) bus.mem_read_addr <= bus.req_addr;
      if (accept && !oor && bus.req_we) begin
        bus.mem_write_addr <= bus.req_addr;
        bus.mem_wr_data <= bus.req_wdata;
      end
    end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized transactions against a timeline/memory reference model
module tb_mem_initiator;
  localparam int TO = 15;
  localparam int LAST = 600;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [0:LAST];
  mem_initiator_if bus ();
  mem_initiator dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one access; delay = strobe cycle in which done is raised, 0 = never
  task automatic txn(input logic we, input int addr, input logic [15:0] wdata, input int delay,
                     input logic hold);
    int t, k, strobes, exp_strobes, exp_k;
    logic r, acc, seen, ok, err, oor;
    logic [15:0] exp_rdata;
    oor = addr > LAST;
    err = oor || delay == 0 || delay > TO;
    exp_strobes = oor ? 0 : (err ? TO : delay);
    exp_k = exp_strobes + 1;
    exp_rdata = (err || we) ? 16'h0 : mem[addr];
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = 13'(addr);
    bus.req_wdata = wdata;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 20) begin
      r = bus.req_ready;
      @(posedge clk);
      #1;
      t++;
      acc = r;
    end
    chk("accept", 32'(acc), 32'd1);
    if (!hold) bus.req_valid = 1'b0;
    k = 1;
    seen = 1'b0;
    strobes = 0;
    ok = 1'b1;
    while (acc && !seen && k < 40) begin
      if (bus.mem_read || bus.mem_write) begin
        strobes++;
        if (bus.mem_read == we || bus.mem_write != we) ok = 1'b0;
        if (we ? (bus.mem_write_addr != 13'(addr) || bus.mem_wr_data != wdata)
               : bus.mem_read_addr != 13'(addr)) ok = 1'b0;
      end
      bus.mem_rd_done = we ? 1'($urandom) : (bus.mem_read && strobes == delay);
      bus.mem_wr_done = we ? (bus.mem_write && strobes == delay) : 1'($urandom);
      bus.mem_rd_data = (!we && bus.mem_rd_done) ? mem[addr] : 16'($urandom);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        if (bus.mem_read || bus.mem_write || bus.req_ready) ok = 1'b0;
        chk("latency", 32'(k), 32'(exp_k));
        chk("rsp_err", 32'(bus.rsp_err), 32'(err));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
        chk("strobe_cycles", 32'(strobes), 32'(exp_strobes));
        chk("protocol", 32'(ok), 32'd1);
      end else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    if (acc) chk("rsp_seen", 32'(seen), 32'd1);
    bus.mem_rd_done = 1'b0;
    bus.mem_wr_done = 1'b0;
    if (we && !err) mem[addr] = wdata;
  endtask

  initial begin
    logic quiet;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_rd_data = '0;
    bus.mem_rd_done = 1'b0;
    bus.mem_wr_done = 1'b0;
    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[5] = 16'hD145;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("rst_addrs", 32'({bus.mem_read_addr, bus.mem_write_addr}), 32'd0);
    chk("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    txn(1'b0, 5, 16'h0, 1, 1'b0);
    txn(1'b1, 518, 16'h000F, 3, 1'b0);
    txn(1'b0, 601, 16'h0, 1, 1'b0);
    txn(1'b0, 10, 16'h0, 0, 1'b0);
    txn(1'b0, 600, 16'h0, 15, 1'b0);
    txn(1'b1, 600, 16'h1234, 16, 1'b0);
    txn(1'b1, 200, 16'hA5A5, 2, 1'b1);
    txn(1'b0, 200, 16'h0, 1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      int a;
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(601, 8191)) : int'($urandom_range(0, LAST));
      txn(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 18)), 1'($urandom));
    end
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 13'd100;
    bus.req_wdata = 16'hBEEF;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    chk("pre_rst_write", 32'(bus.mem_write), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_drop_write", 32'(bus.mem_write), 32'd0);
    chk("async_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid || bus.mem_write || bus.mem_read) quiet = 1'b0;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd1);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
